// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Ports: clk, reset (async, active-high), start/md_op/src_a/src_b issue,
//   flush cancel; busy (reg), stall_req (comb), hi/lo (reg).
module md_unit #(
   parameter int W        = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [2:0]   md_op,
   input  logic [W-1:0] src_a,
   input  logic [W-1:0] src_b,
   input  logic         flush,
   output logic         busy,
   output logic         stall_req,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);

   localparam int MAXL = (MULT_LAT > DIV_LAT) ?
                         MULT_LAT : DIV_LAT;
   localparam int CW = $clog2(MAXL + 1);

   localparam logic [CW-1:0] MCNT = CW'(MULT_LAT - 1);
   localparam logic [CW-1:0] DCNT = CW'(DIV_LAT - 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q;
   logic [W-1:0]    a_q, b_q;

   logic            op_md;
   logic            op_mul_in;
   logic            issue;
   logic            done;
   logic            mt_ok;

   logic            m_sgn;
   logic [2*W-1:0]  ax, bx, prod;
   logic            d_sgn, is_div;
   logic            a_neg, b_neg;
   logic [W-1:0]    ma, mb, uq, ur;
   logic [W-1:0]    q, r;
   logic [2*W-1:0]  res;

   assign op_md = (md_op >= OP_MULT) &&
                  (md_op <= OP_DIVU);
   assign op_mul_in = (md_op == OP_MULT) ||
                      (md_op == OP_MULTU);

   assign stall_req = busy | (start & op_md);

   assign mt_ok = start && !flush &&
                  (state_q == IDLE) &&
                  ((md_op == OP_MTHI) ||
                   (md_op == OP_MTLO));

   // next-state / counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      issue   = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && op_md && !flush) begin
               issue   = 1'b1;
               state_d = RUN;
               cnt_d   = op_mul_in ? MCNT : DCNT;
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               done    = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy    <= (state_d == RUN);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
      end else if (issue) begin
         op_q <= md_op;
         a_q  <= src_a;
         b_q  <= src_b;
      end
   end

   // one 2W multiplier; operands extended per signedness
   always_comb begin
      m_sgn = (op_q == OP_MULT);
      ax    = {{W{m_sgn & a_q[W-1]}}, a_q};
      bx    = {{W{m_sgn & b_q[W-1]}}, b_q};
      prod  = ax * bx;
   end

   // Divide on magnitudes, then restore signs. The overflow case
   // -2^(W-1)/-1 lands on q=-2^(W-1), r=0 without special handling.
   always_comb begin
      is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
      d_sgn  = (op_q == OP_DIV);
      a_neg  = d_sgn & a_q[W-1];
      b_neg  = d_sgn & b_q[W-1];
      ma     = a_neg ? (~a_q + 1'b1) : a_q;
      mb     = b_neg ? (~b_q + 1'b1) : b_q;
      uq     = '0;
      ur     = '0;
      if (mb != '0) begin
         uq = ma / mb;
         ur = ma % mb;
      end
      q = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
      r = a_neg ? (~ur + 1'b1) : ur;
      if (!is_div)
         res = prod;
      else if (b_q == '0)
         res = {a_q, {W{1'b1}}};
      else
         res = {r, q};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (done) begin
         hi <= res[2*W-1:W];
         lo <= res[W-1:0];
      end else if (mt_ok) begin
         if (md_op == OP_MTHI)
            hi <= src_a;
         else
            lo <= src_a;
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed steps with a
// scoreboard queue of expected {hi,lo} results.
module tb_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   md_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .md_op     (md_op),
      .src_a     (src_a),
      .src_b     (src_b),
      .flush     (flush),
      .busy      (busy),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [63:0] sb[$];
   logic [31:0] cur_hi = '0;
   logic [31:0] cur_lo = '0;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model(
      input logic [2:0] op,
      input logic [31:0] a,
      input logic [31:0] b);
      int     sa, sb_, q, r;
      longint p;
      logic [63:0] u;
      sa  = a;
      sb_ = b;
      case (op)
         3'd1: begin
            p = longint'(sa) * longint'(sb_);
            return p;
         end
         3'd2: begin
            u = 64'(a) * 64'(b);
            return u;
         end
         3'd3: begin
            if (b == 0)
               return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               return {32'h0, 32'h8000_0000};
            q = sa / sb_;
            r = sa % sb_;
            return {r, q};
         end
         default: begin
            if (b == 0)
               return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   task automatic issue(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
      start = 1'b1;
      md_op = op;
      src_a = a;
      src_b = b;
      #1;
      check("stall_issue", 64'(stall_req), 64'd1);
      sb.push_back(model(op, a, b));
      step;
      start = 1'b0;
      md_op = 3'd0;
      src_a = $urandom;
      src_b = $urandom;
   endtask

   task automatic finish_op(input string tag,
                            input int lat,
                            input int pre);
      int n;
      logic [63:0] e;
      n = pre;
      while (busy && n < 100) begin
         n++;
         step;
      end
      check({tag, "_lat"}, 64'(n), 64'(lat));
      e = 'x;
      if (sb.size() > 0)
         e = sb.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
      cur_hi = e[63:32];
      cur_lo = e[31:0];
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      md_op = 3'd0;
      src_a = '0;
      src_b = '0;
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_stall", 64'(stall_req), 64'd0);
      reset = 1'b0;
      step;

      issue(3'd1, 32'hFFFF_FFFD, 32'd7);
      finish_op("mult", 5, 0);
      issue(3'd2, 32'hFFFF_FFFF, 32'd2);
      finish_op("multu", 5, 0);
      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      finish_op("div_neg", 10, 0);
      issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      finish_op("div_ovf", 10, 0);
      issue(3'd3, 32'd7, 32'hFFFF_FFFE);
      finish_op("div_negb", 10, 0);
      issue(3'd3, 32'hFFFF_FFF0, 32'd0);
      finish_op("div_z", 10, 0);
      issue(3'd4, 32'h1234_5678, 32'd0);
      finish_op("divu_z", 10, 0);
      issue(3'd4, 32'hF000_0001, 32'd16);
      finish_op("divu", 10, 0);

      for (int i = 0; i < 6; i++) begin
         logic [2:0] op;
         op = 3'($urandom_range(1, 4));
         issue(op, $urandom, $urandom);
         finish_op("rand", (op < 3'd3) ? 5 : 10, 0);
      end

      // MTHI, then MTLO and MULT while busy
      start = 1'b1;
      md_op = 3'd5;
      src_a = 32'hA5A5_A5A5;
      #1;
      check("mthi_stall", 64'(stall_req), 64'd0);
      step;
      start = 1'b0;
      check("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
      check("mthi_lo", 64'(lo), 64'(cur_lo));
      check("mthi_busy", 64'(busy), 64'd0);
      cur_hi = 32'hA5A5_A5A5;
      issue(3'd1, 32'd3, 32'd5);
      start = 1'b1;
      md_op = 3'd6;
      src_a = 32'd1;
      #1;
      check("mtlo_stall", 64'(stall_req), 64'd1);
      step;
      md_op = 3'd1;
      src_a = 32'd7;
      src_b = 32'd7;
      #1;
      check("mult2_stall", 64'(stall_req), 64'd1);
      step;
      start = 1'b0;
      md_op = 3'd0;
      finish_op("mult_busy", 5, 2);
      step;
      check("no_restart", 64'(busy), 64'd0);
      check("no_restart_lo", 64'(lo), 64'd15);

      // flush on busy cycle 3
      issue(3'd3, 32'd100, 32'd7);
      step;
      step;
      flush = 1'b1;
      step;
      flush = 1'b0;
      void'(sb.pop_back());
      check("flush_busy", 64'(busy), 64'd0);
      repeat (12) step;
      check("flush_hi", 64'(hi), 64'(cur_hi));
      check("flush_lo", 64'(lo), 64'(cur_lo));
      check("flush_idle", 64'(busy), 64'd0);

      // flush overrides a same-cycle start
      start = 1'b1;
      flush = 1'b1;
      md_op = 3'd1;
      src_a = 32'd9;
      src_b = 32'd9;
      step;
      start = 1'b0;
      flush = 1'b0;
      check("flush_start", 64'(busy), 64'd0);
      repeat (7) step;
      check("flush_start_lo", 64'(lo), 64'(cur_lo));

      // async reset mid-DIV
      issue(3'd3, 32'd100, 32'd7);
      step;
      step;
      #2;
      reset = 1'b1;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_hi", 64'(hi), 64'd0);
      check("arst_lo", 64'(lo), 64'd0);
      step;
      reset = 1'b0;
      void'(sb.pop_back());
      repeat (12) step;
      check("arst_late_busy", 64'(busy), 64'd0);
      check("arst_late_hi", 64'(hi), 64'd0);
      check("arst_late_lo", 64'(lo), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
